// File: rtl/pad_in_conditioner_pkg.sv
// Shared types and constants for the pad input conditioner.
// Pad indices name the asic_top pads that feed core logic.
package pad_cond_pkg;

    typedef enum logic {
        S_WAIT,
        S_LOCKED
    } strap_state_e;

    localparam int NUM_PADS_DEF   = 82;
    localparam int FILT_CNT_W_DEF = 4;
    localparam int STRAP_W_DEF    = 2;

    localparam int PAD_UART_RX      = 0;
    localparam int PAD_FLASH_MISO   = 12;
    localparam int PAD_CORE_SEL_LSB = 13;
    localparam int PAD_CORE_IRQ     = 15;
    localparam int PAD_GPIO_LSB     = 16;

    // core_irq and the 16 gpio pads are filtered
    localparam logic [NUM_PADS_DEF-1:0] DEFAULT_FILT_MASK =
        82'h0_FFFF_8000;

endpackage

// File: rtl/pad_in_conditioner_if.sv
// Pad-side bundle: raw pads and threshold in,
// conditioned levels, edge pulses and straps out.
interface pad_in_conditioner_if
    import pad_cond_pkg::*;
#(
    parameter int NUM_PADS   = NUM_PADS_DEF,
    parameter int FILT_CNT_W = FILT_CNT_W_DEF,
    parameter int STRAP_W    = STRAP_W_DEF
);
    logic [NUM_PADS-1:0]   io_pad_i;
    logic [FILT_CNT_W-1:0] filt_thresh;
    logic [NUM_PADS-1:0]   pad_sync_o;
    logic [NUM_PADS-1:0]   pad_rise_o;
    logic [NUM_PADS-1:0]   pad_fall_o;
    logic [STRAP_W-1:0]    strap_o;
    logic                  strap_valid_o;

    modport master (
        output io_pad_i, filt_thresh,
        input  pad_sync_o, pad_rise_o, pad_fall_o,
        input  strap_o, strap_valid_o
    );

    modport slave (
        input  io_pad_i, filt_thresh,
        output pad_sync_o, pad_rise_o, pad_fall_o,
        output strap_o, strap_valid_o
    );
endinterface

// File: rtl/pad_in_conditioner_glitch_filter.sv
// One-bit glitch filter: the level follows the synced input
// only after it has differed for the effective threshold.
module pad_glitch_filter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             level_d_o,
    output logic             level_q_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff;
    logic [CNT_W:0]   inc;
    logic             level_q, level_d;

    assign eff = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
    assign inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_i != level_q) begin
            if (inc >= {1'b0, eff}) begin
                level_d = sync_i;
            end else if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_d_o = level_d;
    assign level_q_o = level_q;
endmodule

// File: rtl/pad_in_conditioner.sv
// Pad conditioner: synchronisers, optional glitch filters,
// registered edge pulses and a one-shot boot strap latch.
module pad_in_conditioner
    import pad_cond_pkg::*;
#(
    parameter int NUM_PADS    = NUM_PADS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT_W  = FILT_CNT_W_DEF,
    parameter logic [NUM_PADS-1:0] FILT_MASK = DEFAULT_FILT_MASK,
    parameter int STRAP_LSB   = PAD_CORE_SEL_LSB,
    parameter int STRAP_W     = STRAP_W_DEF,
    parameter int STRAP_DELAY = 32
) (
    input logic clk_pad,
    input logic rst_n_pad,
    pad_in_conditioner_if.slave pif
);
    localparam int DCNT_W = $clog2(STRAP_DELAY + 1);

    logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q;
    logic [NUM_PADS-1:0] level_d, level_q;
    logic [NUM_PADS-1:0] rise_q, rise_d, fall_q, fall_d;
    strap_state_e        state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [STRAP_W-1:0]  strap_q, strap_d;

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pif.io_pad_i};
        end
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        if (FILT_MASK[i]) begin : g_filt
            pad_glitch_filter #(.CNT_W(FILT_CNT_W)) u_filt (
                .clk       (clk_pad),
                .rst_n     (rst_n_pad),
                .sync_i    (sync_q[SYNC_STAGES-1][i]),
                .thresh_i  (pif.filt_thresh),
                .level_d_o (level_d[i]),
                .level_q_o (level_q[i])
            );
        end else begin : g_raw
            // the last sync stage is the level register itself
            assign level_d[i] = sync_q[SYNC_STAGES-2][i];
            assign level_q[i] = sync_q[SYNC_STAGES-1][i];
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        strap_d = strap_q;
        rise_d  = '0;
        fall_d  = '0;
        unique case (state_q)
            S_WAIT: begin
                if (dcnt_q == DCNT_W'(STRAP_DELAY - 1)) begin
                    strap_d = level_q[STRAP_LSB +: STRAP_W];
                    state_d = S_LOCKED;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            S_LOCKED: begin
                rise_d = level_d & ~level_q;
                fall_d = ~level_d & level_q;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            state_q <= S_WAIT;
            dcnt_q  <= '0;
            strap_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            strap_q <= strap_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign pif.pad_sync_o    = level_q;
    assign pif.pad_rise_o    = rise_q;
    assign pif.pad_fall_o    = fall_q;
    assign pif.strap_o       = strap_q;
    assign pif.strap_valid_o = (state_q == S_LOCKED);
endmodule

// File: tb/tb_pad_in_conditioner.sv
// Bench for pad_in_conditioner: directed pad stimulus,
// behavioural model compared every cycle plus literal checks.
module tb_pad_in_conditioner;
    import pad_cond_pkg::*;

    localparam int N = 82;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_in_conditioner_if pif ();

    pad_in_conditioner dut (
        .clk_pad   (clk),
        .rst_n_pad (rst_n),
        .pif       (pif)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [127:0] got,
                       logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Model: level follows input two samples late on raw pads;
    // filtered pads change once the input has differed for
    // eff_thr consecutive samples. Pulses only after lock.
    logic [N-1:0] mask = DEFAULT_FILT_MASK;
    logic [N-1:0] m_lvl, m_p1, m_p2, m_rise, m_fall;
    logic [1:0]   m_strap;
    logic         m_valid;
    int           m_edges;
    int           run [N];

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] old;
        int eff;
        if (!rst_n) begin
            m_lvl = '0; m_p1 = '0; m_p2 = '0;
            m_rise = '0; m_fall = '0;
            m_strap = '0; m_valid = 1'b0; m_edges = 0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            old = m_lvl;
            eff = (pif.filt_thresh == 0) ? 1 : int'(pif.filt_thresh);
            for (int i = 0; i < N; i++) begin
                if (!mask[i]) begin
                    m_lvl[i] = m_p1[i];
                end else if (m_p2[i] != m_lvl[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] >= eff) begin
                        m_lvl[i] = m_p2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_edges++;
            if (m_edges == 32) begin
                m_strap = old[14:13];
                m_valid = 1'b1;
            end
            m_rise = (m_edges <= 32) ? '0 : (m_lvl & ~old);
            m_fall = (m_edges <= 32) ? '0 : (~m_lvl & old);
            m_p2 = m_p1;
            m_p1 = pif.io_pad_i;
        end
    end

    int r15 = 0;
    int f15 = 0;
    logic [N-1:0] any_rise = '0;

    always @(negedge clk) begin
        chk("m_sync", pif.pad_sync_o, m_lvl);
        chk("m_rise", pif.pad_rise_o, m_rise);
        chk("m_fall", pif.pad_fall_o, m_fall);
        chk("m_strap", pif.strap_o, m_strap);
        chk("m_valid", pif.strap_valid_o, m_valid);
        if (pif.pad_rise_o[15]) r15++;
        if (pif.pad_fall_o[15]) f15++;
        any_rise = any_rise | pif.pad_rise_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        pif.io_pad_i = '0;
        pif.io_pad_i[14:13] = 2'b10;
        pif.filt_thresh = 4'd4;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sync", pif.pad_sync_o, '0);
        chk("rst_valid", pif.strap_valid_o, 1'b0);
        chk("rst_strap", pif.strap_o, 2'b00);

        // strap capture
        @(negedge clk);
        rst_n = 1'b1;
        repeat (31) @(negedge clk);
        #1;
        chk("strap_e31_valid", pif.strap_valid_o, 1'b0);
        @(negedge clk);
        #1;
        chk("strap_e32_valid", pif.strap_valid_o, 1'b1);
        chk("strap_e32_val", pif.strap_o, 2'b10);
        pif.io_pad_i[14:13] = 2'b01;
        repeat (4) @(negedge clk);
        #1;
        chk("strap_frozen", pif.strap_o, 2'b10);
        chk("strap_pads_live", pif.pad_sync_o[14:13], 2'b01);

        // unfiltered pad 0
        pif.io_pad_i[0] = 1'b1;
        @(negedge clk); #1;
        chk("p0_k", pif.pad_sync_o[0], 1'b0);
        @(negedge clk); #1;
        chk("p0_k1", pif.pad_sync_o[0], 1'b1);
        chk("p0_rise", pif.pad_rise_o[0], 1'b1);
        @(negedge clk); #1;
        chk("p0_rise_end", pif.pad_rise_o[0], 1'b0);
        pif.io_pad_i[0] = 1'b0;
        repeat (2) @(negedge clk); #1;
        chk("p0_fall", pif.pad_fall_o[0], 1'b1);
        @(negedge clk); #1;
        chk("p0_fall_end", pif.pad_fall_o[0], 1'b0);

        // filtered pad 15, threshold 4
        r15 = 0; f15 = 0;
        pif.io_pad_i[15] = 1'b1;
        repeat (3) @(negedge clk);
        pif.io_pad_i[15] = 1'b0;
        repeat (10) @(negedge clk); #1;
        chk("p15_glitch_rise", r15, 0);
        chk("p15_glitch_lvl", pif.pad_sync_o[15], 1'b0);
        pif.io_pad_i[15] = 1'b1;
        repeat (5) @(negedge clk); #1;
        chk("p15_k4", pif.pad_sync_o[15], 1'b0);
        @(negedge clk); #1;
        chk("p15_k5", pif.pad_sync_o[15], 1'b1);
        chk("p15_k5_rise", pif.pad_rise_o[15], 1'b1);
        pif.io_pad_i[15] = 1'b0;
        repeat (12) @(negedge clk); #1;
        chk("p15_rises", r15, 1);
        chk("p15_falls", f15, 1);
        chk("p15_low", pif.pad_sync_o[15], 1'b0);

        // threshold 0 acts as 1
        pif.filt_thresh = 4'd0;
        pif.io_pad_i[20] = 1'b1;
        @(negedge clk);
        pif.io_pad_i[20] = 1'b0;
        @(negedge clk); #1;
        chk("p20_k1", pif.pad_sync_o[20], 1'b0);
        @(negedge clk); #1;
        chk("p20_k2", pif.pad_sync_o[20], 1'b1);
        chk("p20_rise", pif.pad_rise_o[20], 1'b1);
        repeat (3) @(negedge clk);

        // threshold lowered mid-count
        pif.filt_thresh = 4'd8;
        pif.io_pad_i[21] = 1'b1;
        repeat (7) @(negedge clk); #1;
        chk("p21_cnt5", pif.pad_sync_o[21], 1'b0);
        pif.filt_thresh = 4'd2;
        @(negedge clk); #1;
        chk("p21_lowered", pif.pad_sync_o[21], 1'b1);

        // async reset, then edge suppression and re-capture
        pif.io_pad_i = '1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sync", pif.pad_sync_o, '0);
        chk("arst_rise", pif.pad_rise_o, '0);
        chk("arst_fall", pif.pad_fall_o, '0);
        chk("arst_strap", pif.strap_o, 2'b00);
        chk("arst_valid", pif.strap_valid_o, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        any_rise = '0;
        repeat (10) @(negedge clk); #1;
        chk("wait_sync_ones", pif.pad_sync_o, {N{1'b1}});
        chk("wait_valid", pif.strap_valid_o, 1'b0);
        repeat (21) @(negedge clk); #1;
        chk("wait_no_rise", any_rise, '0);
        chk("wait_e31_valid", pif.strap_valid_o, 1'b0);
        @(negedge clk); #1;
        chk("recap_valid", pif.strap_valid_o, 1'b1);
        chk("recap_strap", pif.strap_o, 2'b11);
        repeat (3) @(negedge clk); #1;
        chk("post_no_rise", any_rise, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
